// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline stall definitions: stall-bus width, hold polarity, stall codes, divide FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package stall_ctrl_pkg;

  localparam int StallBus = 6;

  // Per-bit hold polarity on the stall bus
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall bus: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. Each code holds the requesting stage and everything upstream.
  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallBus-1:0] STALL_ID   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b001111;
  localparam logic [StallBus-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/stall_ctrl_mc_seq.sv
// Multi-cycle divide sequencer: IDLE -> BUSY (MC_CYCLES cycles) -> DONE; raises ex_req while EX must hold.
// Latency: start cycle + MC_CYCLES BUSY cycles, then DONE until EX advances.
// Backpressure: DONE is held while adv=0; a new start is only accepted from IDLE.
// Ports: clk, rst (async active-low), start (accepted divide request), adv (EX not held),
//        busy / done (registered state flags), ex_req (combinational EX stall request).
module stall_ctrl_mc_seq
  import stall_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic adv,
  output logic busy,
  output logic done,
  output logic ex_req
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MC_CYCLES - 1);

  mc_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MC_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (start) begin
            state <= MC_BUSY;
            cnt   <= CntLoad;
            busy  <= 1'b1;
          end
        end
        MC_BUSY: begin
          // Counts down regardless of downstream holds; the divider keeps working under a MEM stall.
          if (cnt == '0) begin
            state <= MC_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MC_DONE: begin
          // Result must stay valid until EX actually consumes it.
          if (adv) begin
            state <= MC_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= MC_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The start cycle itself already holds EX, so the total EX stall is MC_CYCLES+1 cycles.
  assign ex_req = busy | ((state == MC_IDLE) & start);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall sequencer: merges ID/EX/MEM hold requests (MEM > EX > ID) and drives ID instruction capture/replay.
// Latency: stall is combinational from requests; capture/replay state is registered.
// Backpressure: a stall code holds the requesting stage and all upstream stages.
// Ports: clk, rst (async active-low), id_load_use, ex_mc_start, mem_wait -> stall[STALL_W],
//        mc_busy, mc_done, id_inst_capture, id_inst_replay.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int STALL_W   = StallBus,
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_load_use,
  input  logic               ex_mc_start,
  input  logic               mem_wait,
  output logic [STALL_W-1:0] stall,
  output logic               mc_busy,
  output logic               mc_done,
  output logic               id_inst_capture,
  output logic               id_inst_replay
);

  logic               ex_req;
  logic               mc_start;
  logic               adv;
  logic               replay_q;
  logic [STALL_W-1:0] stall_code;

  // A divide request under mem_wait is not accepted; the MEM stall already holds EX.
  assign mc_start = ex_mc_start & ~mem_wait;

  always_comb begin
    stall_code = STALL_W'(STALL_NONE);
    if (mem_wait) begin
      stall_code = STALL_W'(STALL_MEM);
    end else if (ex_req) begin
      stall_code = STALL_W'(STALL_EX);
    end else if (id_load_use) begin
      stall_code = STALL_W'(STALL_ID);
    end
  end

  assign adv = (stall_code[3] == NoStop);

  stall_ctrl_mc_seq #(
    .MC_CYCLES (MC_CYCLES),
    .CNT_W     (CNT_W)
  ) u_mc_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (mc_start),
    .adv    (adv),
    .busy   (mc_busy),
    .done   (mc_done),
    .ex_req (ex_req)
  );

  // Outputs are forced quiet while reset is asserted, independent of the request inputs.
  assign stall = rst ? stall_code : '0;

  // Capture only on the first cycle of a stall holding ID; escalation (ID->EX->MEM) keeps the
  // original capture because replay_q stays set until ID is released.
  assign id_inst_capture = (stall[2] == Stop) & ~replay_q;
  assign id_inst_replay  = replay_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay_q <= 1'b0;
    end else if (id_inst_capture) begin
      replay_q <= 1'b1;
    end else if ((stall[2] == NoStop) && replay_q) begin
      replay_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed scenarios plus randomized traffic, checked against a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stall_ctrl;

  localparam int MC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_load_use = 1'b0;
  logic       ex_mc_start = 1'b0;
  logic       mem_wait = 1'b0;
  logic [5:0] stall;
  logic       mc_busy, mc_done, id_inst_capture, id_inst_replay;

  int errors = 0;
  int checks = 0;

  // Reference model: divide modelled as "busy cycles remaining" plus a result-pending flag,
  // instruction hold as "a held copy exists".
  int   m_busy_left = 0;
  bit   m_result_pending = 0;
  bit   m_held = 0;

  logic [5:0] e_stall;
  logic       e_busy, e_done, e_cap, e_rep;

  int busy_cnt, ex_cnt, done_cnt, cap_cnt;

  stall_ctrl #(
    .STALL_W   (6),
    .MC_CYCLES (MC),
    .CNT_W     (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_load_use     (id_load_use),
    .ex_mc_start     (ex_mc_start),
    .mem_wait        (mem_wait),
    .stall           (stall),
    .mc_busy         (mc_busy),
    .mc_done         (mc_done),
    .id_inst_capture (id_inst_capture),
    .id_inst_replay  (id_inst_replay)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    bit ex_wants;
    if (!rst) begin
      e_stall = 6'b000000;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_cap   = 1'b0;
      e_rep   = 1'b0;
    end else begin
      e_busy   = (m_busy_left > 0);
      e_done   = m_result_pending;
      ex_wants = e_busy || (!e_busy && !m_result_pending && ex_mc_start);
      if (mem_wait)         e_stall = 6'b011111;
      else if (ex_wants)    e_stall = 6'b001111;
      else if (id_load_use) e_stall = 6'b000111;
      else                  e_stall = 6'b000000;
      e_cap = e_stall[2] && !m_held;
      e_rep = m_held;
    end
  endtask

  task automatic model_edge();
    model_eval();
    if (!rst) begin
      m_busy_left      = 0;
      m_result_pending = 0;
      m_held           = 0;
    end else begin
      if (e_cap) m_held = 1;
      else if (!e_stall[2]) m_held = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_result_pending = 1;
      end else if (m_result_pending) begin
        if (!e_stall[3]) m_result_pending = 0;
      end else if (ex_mc_start && !mem_wait) begin
        m_busy_left = MC;
      end
    end
  endtask

  task automatic check(string tag);
    model_eval();
    checks++;
    assert (stall === e_stall) else begin
      errors++; $error("FAIL %s stall got %b want %b", tag, stall, e_stall);
    end
    checks++;
    assert (mc_busy === e_busy) else begin
      errors++; $error("FAIL %s mc_busy got %b want %b", tag, mc_busy, e_busy);
    end
    checks++;
    assert (mc_done === e_done) else begin
      errors++; $error("FAIL %s mc_done got %b want %b", tag, mc_done, e_done);
    end
    checks++;
    assert (id_inst_capture === e_cap) else begin
      errors++; $error("FAIL %s capture got %b want %b", tag, id_inst_capture, e_cap);
    end
    checks++;
    assert (id_inst_replay === e_rep) else begin
      errors++; $error("FAIL %s replay got %b want %b", tag, id_inst_replay, e_rep);
    end
  endtask

  task automatic check_int(string tag, int got, int want);
    checks++;
    assert (got == want) else begin
      errors++; $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: check mid-cycle, tally observed outputs, advance model at the edge, then release for new inputs.
  task automatic tick(string tag);
    @(negedge clk);
    check(tag);
    if (mc_busy) busy_cnt++;
    if (mc_done) done_cnt++;
    if (stall === 6'b001111) ex_cnt++;
    if (id_inst_capture) cap_cnt++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; ex_cnt = 0; done_cnt = 0; cap_cnt = 0;
  endtask

  initial begin
    clear_counts();

    // 1. Reset: outputs quiet even with active requests, then idle after release.
    id_load_use = 1'b1; ex_mc_start = 1'b1; mem_wait = 1'b1;
    tick("rst_held");
    tick("rst_held2");
    id_load_use = 1'b0; ex_mc_start = 1'b0; mem_wait = 1'b0;
    rst = 1'b1;
    tick("idle");
    // async assertion mid-cycle with a MEM stall showing
    mem_wait = 1'b1;
    #2;
    check("mem_before_rst");
    rst = 1'b0;
    #1;
    check("async_rst");
    checks++;
    assert (stall === 6'b000000) else begin
      errors++; $error("FAIL async_rst_stall got %b want 000000", stall);
    end
    @(posedge clk); model_edge(); #1;
    rst = 1'b1; mem_wait = 1'b0;
    tick("post_rst");

    // 2. Single-cycle load-use
    id_load_use = 1'b1;
    tick("lu0");
    id_load_use = 1'b0;
    tick("lu1");
    tick("lu2");

    // 3. Full divide with start held through DONE
    clear_counts();
    ex_mc_start = 1'b1;
    for (int i = 0; i < MC + 2; i++) tick("div");
    ex_mc_start = 1'b0;
    tick("div_idle");
    check_int("div_ex_cycles", ex_cnt, MC + 1);
    check_int("div_busy_cycles", busy_cnt, MC);
    check_int("div_done_cycles", done_cnt, 1);

    // 4. mem_wait lands on DONE for 3 cycles
    clear_counts();
    ex_mc_start = 1'b1;
    tick("div2_start");
    ex_mc_start = 1'b0;
    for (int i = 0; i < MC; i++) tick("div2_busy");
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) tick("done_memwait");
    mem_wait = 1'b0;
    tick("done_release");
    tick("div2_idle");
    check_int("done_hold_cycles", done_cnt, 4);

    // 5. Load-use and divide together
    clear_counts();
    id_load_use = 1'b1; ex_mc_start = 1'b1;
    for (int i = 0; i < MC + 1; i++) tick("lu_div");
    ex_mc_start = 1'b0;
    tick("lu_div_done");
    tick("lu_after1");
    tick("lu_after2");
    id_load_use = 1'b0;
    tick("lu_rel1");
    tick("lu_rel2");
    check_int("lu_div_captures", cap_cnt, 1);
    check_int("lu_div_ex_cycles", ex_cnt, MC + 1);

    // 6. Reset mid-BUSY at cnt=10 aborts the divide
    clear_counts();
    ex_mc_start = 1'b1;
    tick("abort_start");
    ex_mc_start = 1'b0;
    for (int i = 0; i < MC - 11; i++) tick("abort_busy");
    #2;
    rst = 1'b0;
    #1;
    check("abort_rst");
    @(posedge clk); model_edge(); #1;
    rst = 1'b1;
    clear_counts();
    for (int i = 0; i < MC + 8; i++) tick("abort_after");
    check_int("abort_no_done", done_cnt, 0);
    check_int("abort_no_stall", ex_cnt, 0);

    // 7. Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      id_load_use = ($urandom_range(0, 3) == 0);
      ex_mc_start = ($urandom_range(0, 7) == 0);
      mem_wait    = ($urandom_range(0, 4) == 0);
      rst         = ($urandom_range(0, 299) != 0);
      tick("rand");
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. Merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data SRAM wait) into the `StallBus` consumed by PC/IF/ID/EX/MEM/WB. Owns the divide-latency FSM/counter. Owns the ID instruction-hold control (capture/replay) that protects the synchronous inst SRAM output across stalls.

Parameters:
STALL_W, 6, stall bus width; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = stage holds.
MC_CYCLES, 32, divide latency in cycles, counted from the first BUSY cycle.
CNT_W, 6, countdown counter width; must satisfy 2^CNT_W > MC_CYCLES.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
id_load_use  in  1  ID detects a load in EX writing rs/rt of the ID instruction.
ex_mc_start  in  1  EX holds a valid div/divu instruction.
mem_wait  in  1  data SRAM not ready; MEM must hold.
stall  out  STALL_W  per-stage hold vector.
mc_busy  out  1  divider running (state BUSY).
mc_done  out  1  divide result valid to EX (state DONE).
id_inst_capture  out  1  ID latches inst_sram_rdata into its hold register this edge.
id_inst_replay  out  1  ID decodes from its hold register instead of inst_sram_rdata.

Behaviour:
- Stall codes: NONE 6'b000000; ID 6'b000111; EX 6'b001111; MEM 6'b011111.
- Stall is combinational. Priority is MEM > EX > ID:
  - mem_wait=1 -> MEM.
  - Else ex_req -> EX.
  - Else id_load_use -> ID.
  - Else NONE.
- ex_req = (state==IDLE & ex_mc_start) | state==BUSY.
- Divide FSM (mc_seq) states:
  - IDLE: ex_mc_start=1 & mem_wait=0 -> BUSY, cnt<=MC_CYCLES-1. ex_mc_start is ignored while mem_wait=1; the FSM stays IDLE and the MEM stall covers it.
  - BUSY: mc_busy=1. cnt decrements every cycle regardless of mem_wait. When cnt==0 -> DONE.
  - DONE: mc_done=1, ex_req=0, ex_mc_start ignored. Go to IDLE at the edge where stall[3]==0. If mem_wait holds EX, stay in DONE with mc_done held.
- Divide latency: start cycle + MC_CYCLES BUSY cycles, then 1 DONE cycle in which EX advances. EX stall lasts MC_CYCLES+1 cycles.
- Back-to-back divides: a new start is accepted only from IDLE, so there is a minimum 1-cycle IDLE gap.
- Instruction hold:
  - replay_q is registered.
  - id_inst_capture = stall[2] & ~replay_q, i.e. the first cycle of any stall that holds ID.
  - replay_q sets on a capture edge. It clears on an edge with stall[2]==0 and replay_q==1.
  - id_inst_replay = replay_q, so it stays high through the first advancing cycle. ID then consumes the held instruction.
  - A stall that escalates (ID->EX->MEM) without a stall[2]==0 gap produces no second capture.
- Reset (rst=0, async): state IDLE, cnt 0, replay_q 0. Stall, mc_busy, mc_done, id_inst_capture and id_inst_replay are all 0 while rst=0. Reset mid-BUSY aborts the divide; no mc_done pulse follows.
- Simultaneous id_load_use and ex_mc_start: the EX code wins. The load-use request persists after EX releases and is then served.
- No X on outputs when inputs are known. Unknown STALL_W/code combinations are not generated.

Decomposition:
- Shared header lib/defines.vh gains:
  - `StallBus` (=6), `Stop` (1'b1), `NoStop` (1'b0).
  - Stall code constants `STALL_NONE`, `STALL_ID`, `STALL_EX`, `STALL_MEM`.
  - MC state encodings `MC_IDLE`, `MC_BUSY`, `MC_DONE` (2 bits).
- One sub-module, mc_seq: divide FSM plus countdown counter. Ports: clk, rst, start, adv (= ~stall[3]), busy, done, ex_req.
- stall_ctrl holds the priority mux and replay_q.

Test Plan:
1. Reset: rst=0 asserted async mid-cycle -> all outputs 0 immediately. Release, then all inputs 0 -> stall=000000, replay=0.
2. Load-use: id_load_use=1 for 1 cycle ->
   - stall=000111 and capture=1 that cycle.
   - Next cycle stall=000000, replay=1.
   - Following cycle replay=0.
3. Divide, MC_CYCLES=32: ex_mc_start held 1 ->
   - stall=001111 for 33 cycles, mc_busy=1 for 32 cycles.
   - Then mc_done=1 with stall=000000 for 1 cycle.
   - Then IDLE with no restart while start is still 1 in DONE.
4. mem_wait=1 arriving in DONE for 3 cycles -> stall=011111, mc_done stays 1 for 4 cycles total, IDLE after mem_wait drops.
5. Simultaneous id_load_use=1 and ex_mc_start=1 ->
   - stall=001111 throughout the divide and a single capture in cycle 0.
   - After DONE, with load-use still 1, stall=000111 and no new capture.
6. rst=0 at BUSY cnt=10 -> state IDLE. After release with ex_mc_start=0, mc_done never pulses and stall=000000.
